// File: rtl/fifo_lvl_pkg.sv
// Shared definitions for the fill-level FIFO: default geometry/thresholds and the
// per-cycle access classification used by the count update.
package fifo_lvl_pkg;

    localparam int unsigned DEF_ADDR_W    = 4;
    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_AFULL_TH  = 12;
    localparam int unsigned DEF_AEMPTY_TH = 2;

    // Encoded as {write accepted, read accepted} so it can be built by a cast.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

endpackage

// File: rtl/fifo_lvl_dpram.sv
// DEPTH x DATA_W storage for fifo_lvl: one synchronous write port, one asynchronous
// read port. The array is never reset.
module fifo_lvl_dpram #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_lvl.sv
// Synchronous FIFO with fill level, almost-full/almost-empty flags, sticky
// overflow/underflow and synchronous flush. Define FIFO_FWFT_EN for first-word-fall-through.
module fifo_lvl
    import fifo_lvl_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned AFULL_TH  = DEF_AFULL_TH,
    parameter int unsigned AEMPTY_TH = DEF_AEMPTY_TH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr,
    input  logic [DATA_W-1:0] din,
    input  logic              rd,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              afull,
    output logic              aempty,
    output logic [ADDR_W:0]   count,
    output logic              ovf,
    output logic              udf
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned PTR_W = ADDR_W + 1;

    localparam logic [PTR_W-1:0] DEPTH_C  = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AFULL_C  = PTR_W'(AFULL_TH);
    localparam logic [PTR_W-1:0] AEMPTY_C = PTR_W'(AEMPTY_TH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              rd_acc, wr_acc;
    logic              mem_we;
    logic [DATA_W-1:0] rdata;
    op_e               op;

    // Flags come only from the registered count, so wr/rd never reach them combinationally.
    assign full   = (count_q == DEPTH_C);
    assign empty  = (count_q == '0);
    assign afull  = (count_q >= AFULL_C);
    assign aempty = (count_q <= AEMPTY_C);
    assign count  = count_q;
    assign ovf    = ovf_q;
    assign udf    = udf_q;

    // A write into a full FIFO still lands when a read frees a slot in the same cycle.
    assign rd_acc = rd & ~empty;
    assign wr_acc = wr & (~full | rd_acc);
    assign op     = op_e'({wr_acc, rd_acc});
    assign mem_we = wr_acc & ~clr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case (op)
                OP_WR:   count_d = count_q + PTR_W'(1);
                OP_RD:   count_d = count_q - PTR_W'(1);
                default: count_d = count_q;
            endcase
            ovf_d = ovf_q | (wr & ~wr_acc);
            udf_d = udf_q | (rd & empty);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_lvl_dpram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (din),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (rdata)
    );

`ifdef FIFO_FWFT_EN
    assign dout = empty ? '0 : rdata;
`else
    logic [DATA_W-1:0] dout_q;

    // A flush wins over a read in the same cycle, so dout keeps its old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (rd_acc && !clr) begin
            dout_q <= rdata;
        end
    end

    assign dout = dout_q;
`endif

endmodule
